// File: rtl/fifo_unpack.sv
// Unpacks DW-bit words from a show-ahead synchronous FIFO into OW-bit chunks, LSB chunk first,
// over a valid/ready stream with back-to-back word reload on the last chunk.
module fifo_unpack #(
   parameter int DW = 32,
   parameter int OW = 8
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          fifo_empty,
   input  logic [DW-1:0] fifo_rd,
   output logic          fifo_re,
   input  logic          clear,
   output logic          m_valid,
   input  logic          m_ready,
   output logic [OW-1:0] m_data,
   output logic          m_last,
   output logic          busy,
   output logic [15:0]   pop_cnt
);

   localparam int RATIO = DW / OW;
   localparam int IW    = $clog2(RATIO);
   localparam logic [IW-1:0] LAST_IDX = IW'(RATIO - 1);

   generate
      if ((DW % OW) != 0 || (DW / OW) < 2) begin : g_param_check
         $error("fifo_unpack: DW must be an integer multiple of OW with DW/OW >= 2");
      end
   endgenerate

   typedef enum logic {
      EMPTY  = 1'b0,
      ACTIVE = 1'b1
   } state_t;

   state_t          state_q, state_next;
   logic [DW-1:0]   hold_q, hold_next;
   logic [IW-1:0]   idx_q, idx_next;
   logic            pop;
   logic [OW-1:0]   chunks [RATIO];

   genvar gi;
   generate
      for (gi = 0; gi < RATIO; gi++) begin : g_chunk
         assign chunks[gi] = hold_q[gi*OW +: OW];
      end
   endgenerate

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= EMPTY;
         hold_q  <= '0;
         idx_q   <= '0;
         pop_cnt <= '0;
      end else begin
         state_q <= state_next;
         hold_q  <= hold_next;
         idx_q   <= idx_next;
         if (fifo_re) begin
            pop_cnt <= pop_cnt + 16'd1;
         end
      end
   end

   // clear dominates: a handshake in the same cycle is dropped and nothing is popped.
   always_comb begin
      state_next = state_q;
      hold_next  = hold_q;
      idx_next   = idx_q;
      pop        = 1'b0;
      if (clear) begin
         state_next = EMPTY;
         hold_next  = '0;
         idx_next   = '0;
      end else begin
         case (state_q)
            EMPTY: begin
               if (!fifo_empty) begin
                  pop        = 1'b1;
                  hold_next  = fifo_rd;
                  idx_next   = '0;
                  state_next = ACTIVE;
               end
            end
            ACTIVE: begin
               if (m_ready) begin
                  if (idx_q != LAST_IDX) begin
                     idx_next = idx_q + 1'b1;
                  end else if (!fifo_empty) begin
                     pop       = 1'b1;
                     hold_next = fifo_rd;
                     idx_next  = '0;
                  end else begin
                     idx_next   = '0;
                     state_next = EMPTY;
                  end
               end
            end
            default: begin
               state_next = EMPTY;
            end
         endcase
      end
   end

   // Reset is asynchronous, so the pop strobe must also be cut the moment it rises.
   assign fifo_re = pop & ~reset;
   assign m_valid = (state_q == ACTIVE);
   assign busy    = (state_q == ACTIVE);
   assign m_last  = (state_q == ACTIVE) && (idx_q == LAST_IDX);
   assign m_data  = chunks[idx_q];

endmodule

// File: tb/tb_fifo_unpack.sv
// Self-checking bench for fifo_unpack: a queue-based FIFO and chunk-list reference model
// drive directed scenarios and a randomized run, comparing every cycle.
module tb_fifo_unpack;

   localparam int DW    = 32;
   localparam int OW    = 8;
   localparam int RATIO = DW / OW;
   localparam int VW    = OW + 20;

   logic          clk = 1'b0;
   logic          reset;
   logic          fifo_empty;
   logic [DW-1:0] fifo_rd;
   logic          fifo_re;
   logic          clear;
   logic          m_valid;
   logic          m_ready;
   logic [OW-1:0] m_data;
   logic          m_last;
   logic          busy;
   logic [15:0]   pop_cnt;

   always #5 clk = ~clk;

   fifo_unpack #(.DW(DW), .OW(OW)) dut (
      .clk        (clk),
      .reset      (reset),
      .fifo_empty (fifo_empty),
      .fifo_rd    (fifo_rd),
      .fifo_re    (fifo_re),
      .clear      (clear),
      .m_valid    (m_valid),
      .m_ready    (m_ready),
      .m_data     (m_data),
      .m_last     (m_last),
      .busy       (busy),
      .pop_cnt    (pop_cnt)
   );

   int            checks = 0;
   int            errors = 0;
   logic [DW-1:0] fq[$];      // upstream FIFO contents
   logic [OW-1:0] cq[$];      // chunks of the held word not yet accepted
   logic [15:0]   exp_cnt;
   bit            exp_pop;
   logic [VW-1:0] exp_vec, obs_vec;

   // Present the FIFO head, let logic settle, and form expected/observed snapshots.
   task automatic settle();
      bit            v;
      logic [OW-1:0] ed;
      fifo_empty = (fq.size() == 0);
      fifo_rd    = (fq.size() == 0) ? '0 : fq[0];
      #1;
      if (reset || clear)       exp_pop = 1'b0;
      else if (cq.size() == 0)  exp_pop = (fq.size() != 0);
      else                      exp_pop = m_ready && (cq.size() == 1) && (fq.size() != 0);
      v  = (cq.size() != 0);
      ed = '0;
      if (v) ed = cq[0];
      exp_vec = {v, v && (cq.size() == 1), ed, exp_pop, v, exp_cnt};
      obs_vec = {m_valid, m_last, m_valid ? m_data : {OW{1'b0}}, fifo_re, busy, pop_cnt};
   endtask

   // Apply the clock edge to the model, then move to the next falling edge.
   task automatic advance();
      logic [DW-1:0] w;
      logic [OW-1:0] dummy;
      if (!reset) begin
         if (clear) begin
            cq.delete();
         end else begin
            if (cq.size() != 0 && m_ready) dummy = cq.pop_front();
            if (exp_pop) begin
               w = fq.pop_front();
               exp_cnt = exp_cnt + 16'd1;
               for (int k = 0; k < RATIO; k++) cq.push_back(OW'(w >> (OW * k)));
            end
         end
      end
      @(negedge clk);
   endtask

   task automatic test_reset();
      fq.push_back(32'h12345678);
      for (int i = 0; i < 2; i++) begin
         settle();
         checks++;
         if (obs_vec !== exp_vec) begin
            errors++;
            $display("FAIL reset_state cycle %0d: got %h expected %h", i, obs_vec, exp_vec);
         end
         checks++;
         if (m_data !== 8'h00 || fifo_re !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs: got m_data=%h fifo_re=%b expected 00/0", m_data, fifo_re);
         end
         advance();
      end
      fq.delete();
      reset = 1'b0;
   endtask

   task automatic test_single_word();
      logic [OW:0] got[$];
      logic [OW:0] want[4];
      int          first_valid = -1;
      want = '{{1'b0, 8'h11}, {1'b0, 8'h22}, {1'b0, 8'h33}, {1'b1, 8'h44}};
      fq.push_back(32'h44332211);
      m_ready = 1'b1;
      for (int i = 0; i < 7; i++) begin
         settle();
         checks++;
         if (obs_vec !== exp_vec) begin
            errors++;
            $display("FAIL single_word cycle %0d: got %h expected %h", i, obs_vec, exp_vec);
         end
         if (m_valid && first_valid < 0) first_valid = i;
         if (m_valid && m_ready) got.push_back({m_last, m_data});
         advance();
      end
      checks++;
      if (first_valid != 1) begin
         errors++;
         $display("FAIL single_latency: got first valid at cycle %0d expected 1", first_valid);
      end
      for (int i = 0; i < 4; i++) begin
         checks++;
         if (got.size() != 4 || got[i] !== want[i]) begin
            errors++;
            $display("FAIL single_chunk %0d: got %h (n=%0d) expected %h", i,
                     (i < got.size()) ? got[i] : 9'h1ff, got.size(), want[i]);
         end
      end
      checks++;
      if (pop_cnt !== 16'd1) begin
         errors++;
         $display("FAIL single_popcnt: got %0d expected 1", pop_cnt);
      end
   endtask

   task automatic test_back_to_back();
      int  nvalid = 0, firstv = -1, lastv = -1;
      bit  pop_at_a0 = 1'b0;
      fq.push_back(32'hA0A1A2A3);
      fq.push_back(32'hB0B1B2B3);
      m_ready = 1'b1;
      for (int i = 0; i < 11; i++) begin
         settle();
         checks++;
         if (obs_vec !== exp_vec) begin
            errors++;
            $display("FAIL back_to_back cycle %0d: got %h expected %h", i, obs_vec, exp_vec);
         end
         if (m_valid) begin
            nvalid++;
            if (firstv < 0) firstv = i;
            lastv = i;
            if (m_data == 8'hA0 && fifo_re) pop_at_a0 = 1'b1;
         end
         advance();
      end
      checks++;
      if (nvalid != 8 || (lastv - firstv + 1) != 8) begin
         errors++;
         $display("FAIL b2b_stream: got %0d valid over span %0d expected 8/8", nvalid, lastv - firstv + 1);
      end
      checks++;
      if (!pop_at_a0) begin
         errors++;
         $display("FAIL b2b_pop_on_a0: got no pop with A0 handshake expected pop");
      end
      checks++;
      if (pop_cnt !== 16'd3) begin
         errors++;
         $display("FAIL b2b_popcnt: got %0d expected 3", pop_cnt);
      end
   endtask

   task automatic test_stall();
      logic [OW-1:0] got[$];
      logic [OW-1:0] prev_data = '0;
      bit            prev_stall = 1'b0;
      int            pops = 0;
      fq.push_back(32'hDDCCBBAA);
      for (int i = 0; i < 16; i++) begin
         m_ready = (i % 3 == 0);
         settle();
         checks++;
         if (obs_vec !== exp_vec) begin
            errors++;
            $display("FAIL stall cycle %0d: got %h expected %h", i, obs_vec, exp_vec);
         end
         if (prev_stall) begin
            checks++;
            if (!m_valid || m_data !== prev_data) begin
               errors++;
               $display("FAIL stall_hold cycle %0d: got %h expected %h", i, m_data, prev_data);
            end
         end
         if (fifo_re) pops++;
         if (m_valid && m_ready) got.push_back(m_data);
         prev_stall = m_valid && !m_ready;
         prev_data  = m_data;
         advance();
      end
      checks++;
      if (got.size() != 4 || got[0] !== 8'hAA || got[1] !== 8'hBB || got[2] !== 8'hCC || got[3] !== 8'hDD) begin
         errors++;
         $display("FAIL stall_order: got %0d chunks expected AA,BB,CC,DD", got.size());
      end
      checks++;
      if (pops != 1) begin
         errors++;
         $display("FAIL stall_pops: got %0d expected 1", pops);
      end
   endtask

   task automatic test_clear();
      logic [OW-1:0] got[$];
      fq.push_back(32'h04030201);
      fq.push_back(32'h08070605);
      m_ready = 1'b1;
      for (int i = 0; i < 12; i++) begin
         clear = (i == 3 || i == 4);
         settle();
         checks++;
         if (obs_vec !== exp_vec) begin
            errors++;
            $display("FAIL clear cycle %0d: got %h expected %h", i, obs_vec, exp_vec);
         end
         if (i == 3 || i == 4) begin
            checks++;
            if (fifo_re !== 1'b0) begin
               errors++;
               $display("FAIL clear_no_pop cycle %0d: got %b expected 0", i, fifo_re);
            end
         end
         if (i == 4) begin
            checks++;
            if (m_valid !== 1'b0 || busy !== 1'b0) begin
               errors++;
               $display("FAIL clear_idle: got valid=%b busy=%b expected 0/0", m_valid, busy);
            end
         end
         if (i > 4 && m_valid && m_ready) got.push_back(m_data);
         advance();
      end
      clear = 1'b0;
      checks++;
      if (got.size() != 4 || got[0] !== 8'h05) begin
         errors++;
         $display("FAIL clear_restart: got %0d chunks first %h expected 4 first 05",
                  got.size(), (got.size() > 0) ? got[0] : 8'hxx);
      end
   endtask

   task automatic test_reset_mid_word();
      logic [DW-1:0] w[3];
      logic [OW-1:0] got[$];
      for (int i = 0; i < 3; i++) begin
         w[i] = $urandom;
         fq.push_back(w[i]);
      end
      m_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         settle();
         checks++;
         if (obs_vec !== exp_vec) begin
            errors++;
            $display("FAIL rst_mid_pre cycle %0d: got %h expected %h", i, obs_vec, exp_vec);
         end
         if (i < 2) advance();
      end
      reset = 1'b1;
      #1;
      checks++;
      if (m_valid !== 1'b0 || pop_cnt !== 16'd0 || fifo_re !== 1'b0) begin
         errors++;
         $display("FAIL rst_mid_async: got valid=%b cnt=%0d re=%b expected 0/0/0", m_valid, pop_cnt, fifo_re);
      end
      cq.delete();
      exp_cnt = '0;
      advance();
      settle();
      checks++;
      if (obs_vec !== exp_vec) begin
         errors++;
         $display("FAIL rst_mid_held: got %h expected %h", obs_vec, exp_vec);
      end
      advance();
      reset = 1'b0;
      for (int i = 0; i < 12; i++) begin
         settle();
         checks++;
         if (obs_vec !== exp_vec) begin
            errors++;
            $display("FAIL rst_mid_post cycle %0d: got %h expected %h", i, obs_vec, exp_vec);
         end
         if (m_valid && m_ready) got.push_back(m_data);
         advance();
      end
      checks++;
      if (got.size() != 8 || got[0] !== w[1][7:0] || got[4] !== w[2][7:0]) begin
         errors++;
         $display("FAIL rst_mid_resume: got %0d chunks first %h expected 8 first %h",
                  got.size(), (got.size() > 0) ? got[0] : 8'hxx, w[1][7:0]);
      end
      checks++;
      if (pop_cnt !== 16'd2) begin
         errors++;
         $display("FAIL rst_mid_popcnt: got %0d expected 2", pop_cnt);
      end
   endtask

   task automatic test_idle();
      m_ready = 1'b1;
      for (int i = 0; i < 10; i++) begin
         settle();
         checks++;
         if (obs_vec !== exp_vec || fifo_re !== 1'b0 || m_valid !== 1'b0) begin
            errors++;
            $display("FAIL idle cycle %0d: got %h expected %h", i, obs_vec, exp_vec);
         end
         advance();
      end
   endtask

   task automatic test_random();
      for (int i = 0; i < 600; i++) begin
         if ($urandom_range(0, 2) == 0 && fq.size() < 4) fq.push_back($urandom);
         m_ready = ($urandom_range(0, 1) == 1);
         clear   = ($urandom_range(0, 29) == 0);
         settle();
         checks++;
         if (obs_vec !== exp_vec) begin
            errors++;
            $display("FAIL random cycle %0d: got %h expected %h", i, obs_vec, exp_vec);
         end
         advance();
      end
      clear   = 1'b0;
      m_ready = 1'b1;
      for (int i = 0; i < 30; i++) begin
         settle();
         checks++;
         if (obs_vec !== exp_vec) begin
            errors++;
            $display("FAIL random_drain cycle %0d: got %h expected %h", i, obs_vec, exp_vec);
         end
         advance();
      end
   endtask

   initial begin
      reset      = 1'b1;
      clear      = 1'b0;
      m_ready    = 1'b0;
      fifo_empty = 1'b1;
      fifo_rd    = '0;
      exp_cnt    = '0;
      repeat (2) @(negedge clk);
      test_reset();
      test_single_word();
      test_back_to_back();
      test_stall();
      test_clear();
      test_reset_mid_word();
      test_idle();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: got no completion expected finish before 200000");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/fifo_unpack.md
FIFO_UNPACK -- requirements
Module: fifo_unpack

Interface
REQ-001 The block SHALL have parameter DW, default 32, meaning the FIFO word width in bits.
REQ-002 The block SHALL have parameter OW, default 8, meaning the output chunk width in bits.
REQ-003 The block SHALL use derived constants RATIO = DW/OW and IW = $clog2(RATIO); DW SHALL be an integer multiple of OW with RATIO >= 2, else elaboration SHALL fail.
REQ-004 clk  input  1  single clock; all state changes on its rising edge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 fifo_empty  input  1  empty flag from the upstream synchronous FIFO read port.
REQ-007 fifo_rd  input  DW  upstream FIFO head word, combinationally valid whenever fifo_empty=0.
REQ-008 fifo_re  output  1  pop strobe to the upstream FIFO; one pop per clock when high.
REQ-009 clear  input  1  synchronous flush of the held word.
REQ-010 m_valid  output  1  output chunk valid.
REQ-011 m_ready  input  1  downstream accept.
REQ-012 m_data  output  OW  output chunk.
REQ-013 m_last  output  1  high on the final chunk of the current word.
REQ-014 busy  output  1  high while a word is held.
REQ-015 pop_cnt  output  16  count of words popped since reset; wraps 0xFFFF->0.

Function
REQ-016 The block SHALL implement two states: EMPTY (no word held) and ACTIVE (word held in register hold_q, chunk index idx_q of IW bits).
REQ-017 In EMPTY, fifo_re SHALL equal ~fifo_empty & ~clear; on a pop, hold_q<=fifo_rd, idx_q<=0, and the state SHALL become ACTIVE.
REQ-018 In ACTIVE, m_valid SHALL be 1, m_data SHALL be hold_q[idx_q*OW +: OW] (LSB chunk first), and m_last SHALL be (idx_q==RATIO-1).
REQ-019 In ACTIVE, a handshake (m_valid & m_ready) with idx_q<RATIO-1 SHALL increment idx_q without popping.
REQ-020 In ACTIVE, a handshake on the last chunk SHALL pop (fifo_re=1) and reload hold_q with idx_q<=0 if fifo_empty=0, or else transition to EMPTY.
REQ-021 fifo_re SHALL never be 1 while fifo_empty=1, and it SHALL be 0 in every case not covered by REQ-017 and REQ-020.
REQ-022 m_data and m_last SHALL hold stable while m_valid=1 and m_ready=0.
REQ-023 m_valid SHALL be 0 in EMPTY, and m_valid SHALL never depend combinationally on m_ready.
REQ-024 Latency: the first chunk of a word SHALL be valid in the cycle after the pop cycle (one cycle after fifo_empty falls while in EMPTY).
REQ-025 Throughput: with m_ready held 1 and the FIFO never empty, the block SHALL emit one chunk per clock with no bubble between words.
REQ-026 clear=1 SHALL override all else: next state EMPTY, idx_q<=0, fifo_re=0 that cycle, and any concurrent handshake SHALL be discarded with no pop.
REQ-027 busy SHALL be 1 exactly in ACTIVE.
REQ-028 pop_cnt SHALL increment by 1 on every cycle with fifo_re=1, and clear SHALL NOT affect it.

Reset
REQ-029 While reset=1, the block SHALL hold state EMPTY, idx_q=0, hold_q=0, pop_cnt=0, and outputs m_valid=0, m_last=0, m_data=0, busy=0, fifo_re=0 (fifo_re gated by reset).
REQ-030 Reset asserted mid-word SHALL discard the held word immediately and asynchronously, with no further pop.
REQ-031 After reset deassertion, operation SHALL resume per REQ-017 from the next rising edge.

Verification (DW=32, OW=8)
REQ-032 FIFO holds 0x44332211, m_ready=1 -> one pop; m_data 0x11,0x22,0x33,0x44 on consecutive cycles, m_last only on 0x44, then m_valid=0, pop_cnt=1.
REQ-033 FIFO holds 0xA0A1A2A3 and 0xB0B1B2B3, m_ready=1 -> 8 consecutive valid cycles, second pop coincides with the 0xA0 handshake, no bubble, pop_cnt=2.
REQ-034 m_ready toggled 1,0,0,1,... on word 0xDDCCBBAA -> each chunk held stable across stall cycles; order 0xAA,0xBB,0xCC,0xDD; exactly one pop.
REQ-035 clear=1 while idx_q=2 and m_ready=1 -> next cycle m_valid=0, busy=0, no pop that cycle; the next FIFO word starts at chunk 0.
REQ-036 reset asserted during chunk 1 of a word with 3 words queued -> m_valid=0 and pop_cnt=0 immediately; after release the next queued word is popped and emitted from chunk 0.
REQ-037 FIFO empty for 10 cycles with m_ready=1 -> fifo_re=0 and m_valid=0 throughout.
